// File: rtl/dsm_cic_decimator.sv
// Nth-order CIC decimator for a 1-bit delta-sigma stream; one sample per R enabled cycles.
// dout/dout_valid appear one clk after the tick; no backpressure, clk_en is the only throttle.
module dsm_cic_decimator #(
    parameter int WIDTH = 16,
    parameter int R     = 50,
    parameter int N     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic                    dsm_in,
    output logic signed [WIDTH-1:0] dout,
    output logic                    dout_valid,
    output logic                    settled
);

    localparam int ACC_W = N * $clog2(R) + 2;
    localparam int CNT_W = $clog2(R);

    logic signed [ACC_W-1:0] r_int [N];
    logic signed [ACC_W-1:0] r_d   [N];
    logic signed [ACC_W-1:0] r_cn;
    logic [CNT_W-1:0]        r_cnt;
    logic [2:0]              r_settle_cnt;
    logic                    r_dout_valid;
    logic                    r_settled;

    logic signed [ACC_W-1:0] w_x;
    logic signed [ACC_W-1:0] w_stage_in [N];
    logic signed [ACC_W-1:0] w_cn;
    logic                    w_tick;

    assign w_x    = dsm_in ? ACC_W'(1) : {ACC_W{1'b1}};
    assign w_tick = clk_en && (r_cnt == CNT_W'(R - 1));

    // Comb chain is evaluated only at the decimated rate; wrap-around cancels in the differences.
    always_comb begin
        w_cn = r_int[N-1];
        for (int k = 0; k < N; k++) begin
            w_stage_in[k] = w_cn;
            w_cn          = w_cn - r_d[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                r_int[k] <= '0;
            end
        end else if (clk_en) begin
            r_int[0] <= r_int[0] + w_x;
            for (int k = 1; k < N; k++) begin
                r_int[k] <= r_int[k] + r_int[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clk_en) begin
            r_cnt <= (r_cnt == CNT_W'(R - 1)) ? '0 : r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                r_d[k] <= '0;
            end
            r_cn         <= '0;
            r_dout_valid <= 1'b0;
            r_settle_cnt <= '0;
            r_settled    <= 1'b0;
        end else begin
            r_dout_valid <= w_tick;
            if (w_tick) begin
                for (int k = 0; k < N; k++) begin
                    r_d[k] <= w_stage_in[k];
                end
                r_cn <= w_cn;
                // First N outputs still carry the comb start-up transient.
                if (r_settle_cnt == 3'(N)) begin
                    r_settled <= 1'b1;
                end else begin
                    r_settle_cnt <= r_settle_cnt + 3'd1;
                end
            end
        end
    end

    generate
        if (WIDTH >= ACC_W) begin : g_wide
            assign dout = WIDTH'(r_cn) <<< (WIDTH - ACC_W);
        end else begin : g_narrow
            assign dout = r_cn[ACC_W-1 -: WIDTH];
        end
    endgenerate

    assign dout_valid = r_dout_valid;
    assign settled    = r_settled;

endmodule

// File: tb/tb_dsm_cic_decimator.sv
// Bench for dsm_cic_decimator: scenario table plus reset corner sequence, checked
// against a direct triangular-kernel model through a scoreboard queue.
module tb_dsm_cic_decimator;

    localparam int WIDTH = 16;
    localparam int R     = 50;
    localparam int N     = 2;
    localparam int ACC_W = N * $clog2(R) + 2;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    clk_en = 1'b0;
    logic                    dsm_in = 1'b0;
    logic signed [WIDTH-1:0] dout;
    logic                    dout_valid;
    logic                    settled;

    dsm_cic_decimator #(.WIDTH(WIDTH), .R(R), .N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .dsm_in     (dsm_in),
        .dout       (dout),
        .dout_valid (dout_valid),
        .settled    (settled)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [WIDTH-1:0] dout;
        logic                    settled;
    } exp_t;

    // mode: 0 ones, 1 zeros, 2 alternating, 3 random; period 0 = random enable
    typedef struct {
        int mode;
        int period;
        int steps;
        bit use_c;
        int exp_c;
    } scen_t;

    exp_t  sb_q[$];
    scen_t tbl[7];
    int    checks = 0;
    int    errors = 0;

    int                      hist[256];
    int                      m_n;
    int                      m_strobes;
    logic                    m_settled;
    logic                    m_vld;
    logic signed [WIDTH-1:0] m_last;
    bit                      m_const_en;
    int                      m_const;

    function automatic int fpos(input int k);
        return (k > 0) ? k : 0;
    endfunction

    // Output m as a direct FIR over the input history (triangular CIC kernel).
    function automatic logic signed [WIDTH-1:0] model_y(input int m);
        int y;
        int lo;
        logic signed [ACC_W-1:0] y_acc;
        y  = 0;
        lo = (m - 2) * R - 2;
        if (lo < 0) lo = 0;
        for (int i = lo; i <= m * R - 3; i++) begin
            y += hist[i % 256] * (fpos(m*R - 2 - i) - 2 * fpos((m-1)*R - 2 - i) + fpos((m-2)*R - 2 - i));
        end
        y_acc = ACC_W'(y);
        return WIDTH'(int'(y_acc) * (1 << (WIDTH - ACC_W)));
    endfunction

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_n       = 0;
        m_strobes = 0;
        m_settled = 1'b0;
        m_last    = '0;
        sb_q.delete();
    endtask

    task automatic step(input logic en, input logic b, input string tag);
        exp_t e;
        @(negedge clk);
        clk_en = en;
        dsm_in = b;
        m_vld  = 1'b0;
        if (en) begin
            hist[m_n % 256] = b ? 1 : -1;
            if (m_n % R == R - 1) begin
                m_strobes++;
                e.dout    = model_y(m_strobes);
                m_settled = (m_strobes >= N + 1);
                e.settled = m_settled;
                m_last    = e.dout;
                sb_q.push_back(e);
                m_vld = 1'b1;
            end
            m_n++;
        end
        @(posedge clk);
        #1;
        chk({tag, " dout_valid"}, dout_valid, m_vld);
        if (dout_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s strobe: got unexpected strobe, expected none at %0t", tag, $time);
            end else begin
                e = sb_q.pop_front();
                chk({tag, " dout"}, dout, e.dout);
                chk({tag, " settled@strobe"}, settled, e.settled);
                if (m_const_en && e.settled) chk({tag, " steady"}, dout, m_const);
            end
        end else begin
            chk({tag, " hold"}, dout, m_last);
            chk({tag, " settled"}, settled, m_settled);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        clk_en = 1'b0;
        rst    = 1'b1;
        #1;
        chk("rst dout", dout, 0);
        chk("rst dout_valid", dout_valid, 0);
        chk("rst settled", settled, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic en;
        logic b;
        model_reset();
        m_const_en = 0;
        m_const    = 0;

        #1;
        chk("por dout", dout, 0);
        chk("por dout_valid", dout_valid, 0);
        chk("por settled", settled, 0);

        tbl[0] = '{mode: 0, period: 1, steps: 300,   use_c: 1, exp_c: 10000};
        tbl[1] = '{mode: 1, period: 1, steps: 300,   use_c: 1, exp_c: -10000};
        tbl[2] = '{mode: 2, period: 1, steps: 300,   use_c: 1, exp_c: 0};
        tbl[3] = '{mode: 0, period: 4, steps: 1400,  use_c: 1, exp_c: 10000};
        tbl[4] = '{mode: 3, period: 1, steps: 600,   use_c: 0, exp_c: 0};
        tbl[5] = '{mode: 3, period: 0, steps: 800,   use_c: 0, exp_c: 0};
        tbl[6] = '{mode: 0, period: 1, steps: 20000, use_c: 1, exp_c: 10000};

        for (int s = 0; s < 7; s++) begin
            do_reset();
            m_const_en = tbl[s].use_c;
            m_const    = tbl[s].exp_c;
            for (int c = 0; c < tbl[s].steps; c++) begin
                if (tbl[s].period == 0) en = 1'($urandom_range(0, 1));
                else                    en = (c % tbl[s].period == 0);
                case (tbl[s].mode)
                    0:       b = 1'b1;
                    1:       b = 1'b0;
                    2:       b = (m_n % 2 == 0);
                    default: b = 1'($urandom_range(0, 1));
                endcase
                step(en, b, $sformatf("scen%0d", s));
            end
            chk($sformatf("scen%0d strobes", s), m_strobes, tbl[s].steps / ((tbl[s].period == 0) ? 1 : tbl[s].period) / R * ((tbl[s].period == 0) ? 0 : 1) + ((tbl[s].period == 0) ? m_n / R : 0));
            chk($sformatf("scen%0d drained", s), sb_q.size(), 0);
        end

        // Reset pulse mid-window after settling: partial window is dropped.
        do_reset();
        m_const_en = 1;
        m_const    = 10000;
        for (int c = 0; c < 3 * R + 25; c++) step(1'b1, 1'b1, "pre");
        chk("pre settled", settled, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid rst dout", dout, 0);
        chk("mid rst dout_valid", dout_valid, 0);
        chk("mid rst settled", settled, 0);
        @(posedge clk);
        #1;
        chk("mid rst hold dout", dout, 0);
        @(negedge clk);
        rst    = 1'b0;
        clk_en = 1'b0;
        model_reset();
        for (int c = 0; c < R - 1; c++) step(1'b1, 1'b1, "post");
        chk("no early strobe", dout_valid, 0);
        step(1'b1, 1'b1, "post");
        chk("first strobe", dout_valid, 1);
        chk("strobe1 settled", settled, 0);
        for (int c = 0; c < R; c++) step(1'b1, 1'b1, "post");
        chk("strobe2 settled", settled, 0);
        for (int c = 0; c < R; c++) step(1'b1, 1'b1, "post");
        chk("strobe3 settled", settled, 1);
        chk("strobe3 dout", dout, 10000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
